avalon_led_pio: RTL

- Parametrised Avalon-MM output PIO, generalising the fixed 2-bit LED port to WIDTH channels.
- Adds atomic set/clear/toggle writes and a per-channel hardware blink engine driven by a programmable prescaler.
- Sits on the Nios system interconnect as a zero-wait-state slave; out_port drives board LEDs directly.

---
 rtl/led_pio_pkg.sv | 14 +
 rtl/led_blink_timer.sv | 40 ++++
 rtl/avalon_led_pio.sv | 103 ++++++++++
 3 files changed

// File: rtl/led_pio_pkg.sv
// Shared constants for the Avalon LED PIO: register addresses, STATUS bit index, PWM width.
package led_pio_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_DUTY   = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int PWM_W            = 8;
endpackage

// File: rtl/led_blink_timer.sv
// Blink half-period timer: counts to period-1, then flips phase and pulses tick for one cycle.
module led_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  input  logic                resync,
  output logic                phase,
  output logic                tick
);
  logic [PERIOD_W-1:0] count;
  logic                terminal;

  assign terminal = (count == period - PERIOD_W'(1));

  // resync outranks both a period reload and a terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b0;
      tick  <= 1'b0;
    end else if (resync) begin
      count <= '0;
      phase <= 1'b0;
      tick  <= 1'b0;
    end else if (load || period == '0) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (terminal) begin
      count <= '0;
      phase <= ~phase;
      tick  <= 1'b1;
    end else begin
      count <= count + PERIOD_W'(1);
      tick  <= 1'b0;
    end
  end
endmodule

// File: rtl/avalon_led_pio.sv
// Avalon-MM LED output PIO with set/clear/toggle writes and per-channel hardware blink.
// Optional duty-cycle PWM on address 7 when LED_PIO_PWM_EN is defined.
module avalon_led_pio
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             blink_tick
);
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic                wr;
  logic                resync;
  logic                period_load;
  logic [WIDTH-1:0]    wd;
  logic [WIDTH-1:0]    blink_out;

  assign wr          = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign resync      = wr && (address == ADDR_STATUS) && writedata[STATUS_PHASE_BIT];
  assign period_load = wr && (address == ADDR_PERIOD);

`ifdef LED_PIO_PWM_EN
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RESET_VALUE;
      mask   <= '0;
      period <= '0;
`ifdef LED_PIO_PWM_EN
      duty   <= {PWM_W{1'b1}};
`endif
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data   <= wd;
        ADDR_SET:    data   <= data | wd;
        ADDR_CLEAR:  data   <= data & ~wd;
        ADDR_TOGGLE: data   <= data ^ wd;
        ADDR_MASK:   mask   <= wd;
        ADDR_PERIOD: period <= writedata[PERIOD_W-1:0];
`ifdef LED_PIO_PWM_EN
        ADDR_DUTY:   duty   <= writedata[PWM_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  led_blink_timer #(.PERIOD_W(PERIOD_W)) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .load    (period_load),
    .resync  (resync),
    .phase   (phase),
    .tick    (blink_tick)
  );

  assign blink_out = data ^ (mask & {WIDTH{phase}});

`ifdef LED_PIO_PWM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  // all-ones duty is a hard "always on" rather than 255/256
  assign pwm_on   = (duty == {PWM_W{1'b1}}) | (pwm_cnt < duty);
  assign out_port = blink_out & {WIDTH{pwm_on}};
`else
  assign out_port = blink_out;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: readdata[WIDTH-1:0] = data;
      ADDR_MASK:   readdata[WIDTH-1:0]       = mask;
      ADDR_PERIOD: readdata[PERIOD_W-1:0]    = period;
      ADDR_STATUS: readdata[STATUS_PHASE_BIT] = phase;
`ifdef LED_PIO_PWM_EN
      ADDR_DUTY:   readdata[PWM_W-1:0]       = duty;
`endif
      default: ;
    endcase
  end
endmodule
